// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding, parity codes and oversample limits
package uart_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK} uart_state_t;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD = 1;
    localparam int PAR_EVEN = 2;
    localparam int OS_LO = 8;
    localparam int OS_HI = 16;
    function automatic bit os_legal(input int os);
        return os == OS_LO || os == OS_HI;
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: phase-accumulator tick generator producing TICK_RATE ticks/s from CLOCK_FREQUENCY
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int TICK_RATE = 1_843_200
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam logic [47:0] INC = 48'(TICK_RATE);
    localparam logic [47:0] CF = 48'(CLOCK_FREQUENCY);
    logic [47:0] acc;
    assign tick = acc >= CF;
    always_ff @(posedge clk)
        acc <= !rst_n ? '0 : tick ? acc + INC - CF : acc + INC;
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: configurable-frame UART receiver with majority vote; UART_RX_FRAME_BREAK_EN enables break detection
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int WORD_WIDTH = 8,
    parameter int OS = 16,
    parameter int PARITY = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    output logic [WORD_WIDTH-1:0] dout,
    output logic                  perr,
    output logic                  ferr,
    output logic                  we,
    input  logic                  full,
    output logic                  ovr,
    input  logic                  ovr_clr,
    output logic                  brk
);
    if (BAUD_RATE * OS > CLOCK_FREQUENCY || WORD_WIDTH < 5 || WORD_WIDTH > 9 || !os_legal(OS) ||
        PARITY < PAR_NONE || PARITY > PAR_EVEN || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
        $error("uart_rx_frame: illegal parameter set");
    end
    localparam logic [3:0] SA = 4'(OS / 2 - 2);
    localparam logic [3:0] SB = 4'(OS / 2 - 1);
    localparam logic [3:0] HALF = 4'(OS / 2);
    localparam logic [3:0] LAST = 4'(OS - 1);
    localparam logic [3:0] WLAST = 4'(WORD_WIDTH - 1);
    localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);
    localparam logic ODD = PARITY == PAR_ODD;
    logic sync1, rx_sync, os_tick, s_a, s_b, vote, perr_acc, ferr_acc, ferr_now;
    logic at_vote, at_last, emit, brk_hit;
    logic [3:0] os_cnt, bit_cnt;
    logic [WORD_WIDTH-1:0] shreg;
    uart_state_t state, state_nxt;
    uart_baud_tick #(.CLOCK_FREQUENCY(CLOCK_FREQUENCY), .TICK_RATE(BAUD_RATE * OS)) u_tick (
        .clk(clk), .rst_n(rst_n), .tick(os_tick)
    );
    always_ff @(posedge clk)
        {sync1, rx_sync} <= !rst_n ? 2'b11 : {din, sync1};
    assign vote = (s_a & s_b) | (s_a & rx_sync) | (s_b & rx_sync);
    assign at_vote = os_tick && os_cnt == HALF;
    assign at_last = os_tick && os_cnt == LAST;
    assign ferr_now = ferr_acc | ~vote;
    always_comb begin
        state_nxt = state;
        emit = 1'b0;
        brk_hit = 1'b0;
        case (state)
            ST_IDLE:   if (os_tick && !rx_sync) state_nxt = ST_START;
            ST_START:  state_nxt = at_vote && vote ? ST_IDLE : at_last ? ST_DATA : state;
            ST_DATA:   if (at_last && bit_cnt == WLAST) state_nxt = PARITY != PAR_NONE ? ST_PARITY : ST_STOP;
            ST_PARITY: if (at_last) state_nxt = ST_STOP;
            ST_STOP: if (at_vote && bit_cnt == SLAST) begin
`ifdef UART_RX_FRAME_BREAK_EN
                // with all-zero data the stored parity result reveals the parity vote itself
                brk_hit = shreg == '0 && ferr_now && perr_acc == ODD;
`endif
                emit = !brk_hit;
                state_nxt = brk_hit ? ST_BREAK : ST_IDLE;
            end
`ifdef UART_RX_FRAME_BREAK_EN
            ST_BREAK:  if (os_tick && rx_sync) state_nxt = ST_IDLE;
`endif
            default:   state_nxt = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            os_cnt <= '0;
            bit_cnt <= '0;
            shreg <= '0;
            {s_a, s_b} <= 2'b11;
            {perr_acc, ferr_acc} <= 2'b00;
            dout <= '0;
            {perr, ferr, we, ovr, brk} <= '0;
        end else begin
            state <= state_nxt;
            we <= emit && !full;
            brk <= brk_hit;
            ovr <= (emit && full) || (ovr && !ovr_clr);
            if (emit && !full) begin
                dout <= shreg;
                perr <= perr_acc;
                ferr <= ferr_now;
            end
            if (os_tick) begin
                os_cnt <= (state == ST_IDLE || state == ST_BREAK || os_cnt == LAST) ? '0 : os_cnt + 4'd1;
                if (os_cnt == SA) s_a <= rx_sync;
                if (os_cnt == SB) s_b <= rx_sync;
                if (state == ST_IDLE) begin
                    {perr_acc, ferr_acc} <= 2'b00;
                    bit_cnt <= '0;
                end
                if (at_vote && state == ST_DATA) shreg <= {vote, shreg[WORD_WIDTH-1:1]};
                if (at_vote && state == ST_PARITY) perr_acc <= vote ^ (^shreg) ^ ODD;
                if (at_vote && state == ST_STOP) ferr_acc <= ferr_now;
                if (at_last && (state == ST_DATA || state == ST_STOP))
                    bit_cnt <= (state == ST_DATA && bit_cnt == WLAST) ? '0 : bit_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed checks of uart_rx_frame over 8N1, 8E1, 8N2 and 7O1 (OS=8) instances
module tb_uart_rx_frame;
    localparam int CF = 3_686_400;
    localparam int BR = 115200;
    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] din, we, perr, ferr, ovr, brk;
    logic full, ovr_clr;
    logic [7:0] dout0, dout1, dout2;
    logic [6:0] dout3;
    int tests = 0;
    int fails = 0;
    int we_cnt[4];
    int brk_cnt[4];
    always #5 clk = ~clk;
    uart_rx_frame #(.CLOCK_FREQUENCY(CF), .BAUD_RATE(BR)) u0 (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .dout(dout0), .perr(perr[0]), .ferr(ferr[0]),
        .we(we[0]), .full(full), .ovr(ovr[0]), .ovr_clr(ovr_clr), .brk(brk[0]));
    uart_rx_frame #(.CLOCK_FREQUENCY(CF), .BAUD_RATE(BR), .PARITY(2)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .dout(dout1), .perr(perr[1]), .ferr(ferr[1]),
        .we(we[1]), .full(full), .ovr(ovr[1]), .ovr_clr(ovr_clr), .brk(brk[1]));
    uart_rx_frame #(.CLOCK_FREQUENCY(CF), .BAUD_RATE(BR), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .din(din[2]), .dout(dout2), .perr(perr[2]), .ferr(ferr[2]),
        .we(we[2]), .full(full), .ovr(ovr[2]), .ovr_clr(ovr_clr), .brk(brk[2]));
    uart_rx_frame #(.CLOCK_FREQUENCY(CF), .BAUD_RATE(BR), .WORD_WIDTH(7), .OS(8), .PARITY(1)) u3 (
        .clk(clk), .rst_n(rst_n), .din(din[3]), .dout(dout3), .perr(perr[3]), .ferr(ferr[3]),
        .we(we[3]), .full(full), .ovr(ovr[3]), .ovr_clr(ovr_clr), .brk(brk[3]));

    always @(negedge clk)
        for (int i = 0; i < 4; i++) begin
            if (we[i]) we_cnt[i]++;
            if (brk[i]) brk_cnt[i]++;
        end

    // one bit = 32 clk; an optional 2-clk inverted spike lands on the OS/2-1 sample
    task automatic send_bit(input int d, input logic v, input bit spike);
        din[d] = v;
        repeat (16) @(negedge clk);
        if (spike) din[d] = ~v;
        repeat (2) @(negedge clk);
        din[d] = v;
        repeat (14) @(negedge clk);
    endtask

    task automatic send_frame(input int d, input logic [8:0] data, input int nb, input bit has_par,
                              input logic par, input logic st0, input logic st1, input int nst,
                              input int spike_bit);
        send_bit(d, 1'b0, 1'b0);
        for (int i = 0; i < nb; i++) send_bit(d, data[i], i == spike_bit);
        if (has_par) send_bit(d, par, 1'b0);
        send_bit(d, st0, 1'b0);
        if (nst == 2) send_bit(d, st1, 1'b0);
        din[d] = 1'b1;
        repeat (48) @(negedge clk);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({we[i], perr[i], ferr[i], ovr[i], brk[i]} !== 5'b0) begin
                fails++;
                $display("FAIL reset_flags[%0d]: got %b want 00000", i, {we[i], perr[i], ferr[i], ovr[i], brk[i]});
            end
        end
        tests++;
        if ({dout0, dout1, dout2, dout3} !== 31'h0) begin
            fails++;
            $display("FAIL reset_dout: got %h want 0", {dout0, dout1, dout2, dout3});
        end
    endtask

    task automatic test_8n1;
        int n0, n3;
        n0 = we_cnt[0];
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        tests++;
        if (we_cnt[0] - n0 !== 1 || dout0 !== 8'hA5 || perr[0] !== 1'b0 || ferr[0] !== 1'b0) begin
            fails++;
            $display("FAIL 8n1_a5: we %0d dout %h perr %b ferr %b want 1 a5 0 0", we_cnt[0] - n0, dout0, perr[0], ferr[0]);
        end
        n3 = we_cnt[3];
        send_frame(3, 9'h055, 7, 1, 1'b1, 1'b1, 1'b1, 1, -1);
        tests++;
        if (we_cnt[3] - n3 !== 1 || dout3 !== 7'h55 || perr[3] !== 1'b0) begin
            fails++;
            $display("FAIL 7o1_good: we %0d dout %h perr %b want 1 55 0", we_cnt[3] - n3, dout3, perr[3]);
        end
        send_frame(3, 9'h055, 7, 1, 1'b0, 1'b1, 1'b1, 1, -1);
        tests++;
        if (we_cnt[3] - n3 !== 2 || perr[3] !== 1'b1) begin
            fails++;
            $display("FAIL 7o1_bad: we %0d perr %b want 2 1", we_cnt[3] - n3, perr[3]);
        end
    endtask

    task automatic test_parity;
        int n;
        n = we_cnt[1];
        send_frame(1, 9'h03C, 8, 1, 1'b1, 1'b1, 1'b1, 1, -1);
        tests++;
        if (we_cnt[1] - n !== 1 || dout1 !== 8'h3C || perr[1] !== 1'b1) begin
            fails++;
            $display("FAIL even_bad: we %0d dout %h perr %b want 1 3c 1", we_cnt[1] - n, dout1, perr[1]);
        end
        send_frame(1, 9'h03C, 8, 1, 1'b0, 1'b1, 1'b1, 1, -1);
        tests++;
        if (we_cnt[1] - n !== 2 || dout1 !== 8'h3C || perr[1] !== 1'b0) begin
            fails++;
            $display("FAIL even_good: we %0d dout %h perr %b want 2 3c 0", we_cnt[1] - n, dout1, perr[1]);
        end
    endtask

    task automatic test_framing;
        int n0, n2;
        n0 = we_cnt[0];
        send_frame(0, 9'h055, 8, 0, 1'b0, 1'b0, 1'b1, 1, -1);
        tests++;
        if (we_cnt[0] - n0 !== 1 || dout0 !== 8'h55 || ferr[0] !== 1'b1) begin
            fails++;
            $display("FAIL stop0: we %0d dout %h ferr %b want 1 55 1", we_cnt[0] - n0, dout0, ferr[0]);
        end
        n2 = we_cnt[2];
        send_frame(2, 9'h05A, 8, 0, 1'b0, 1'b1, 1'b1, 2, -1);
        tests++;
        if (we_cnt[2] - n2 !== 1 || dout2 !== 8'h5A || ferr[2] !== 1'b0) begin
            fails++;
            $display("FAIL two_stop_ok: we %0d dout %h ferr %b want 1 5a 0", we_cnt[2] - n2, dout2, ferr[2]);
        end
        send_frame(2, 9'h055, 8, 0, 1'b0, 1'b1, 1'b0, 2, -1);
        tests++;
        if (we_cnt[2] - n2 !== 2 || dout2 !== 8'h55 || ferr[2] !== 1'b1) begin
            fails++;
            $display("FAIL two_stop_bad: we %0d dout %h ferr %b want 2 55 1", we_cnt[2] - n2, dout2, ferr[2]);
        end
    endtask

    task automatic test_overrun;
        int n;
        n = we_cnt[0];
        full = 1'b1;
        send_frame(0, 9'h012, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        tests++;
        if (we_cnt[0] - n !== 0 || ovr[0] !== 1'b1 || dout0 !== 8'h55 || ferr[0] !== 1'b1) begin
            fails++;
            $display("FAIL drop: we %0d ovr %b dout %h ferr %b want 0 1 55 1", we_cnt[0] - n, ovr[0], dout0, ferr[0]);
        end
        full = 1'b0;
        repeat (100) @(negedge clk);
        tests++;
        if (ovr[0] !== 1'b1) begin
            fails++;
            $display("FAIL ovr_sticky: got %b want 1", ovr[0]);
        end
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        tests++;
        if (ovr[0] !== 1'b0) begin
            fails++;
            $display("FAIL ovr_clr: got %b want 0", ovr[0]);
        end
        send_frame(0, 9'h034, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        tests++;
        if (we_cnt[0] - n !== 1 || dout0 !== 8'h34 || ferr[0] !== 1'b0 || ovr[0] !== 1'b0) begin
            fails++;
            $display("FAIL after_clr: we %0d dout %h ferr %b ovr %b want 1 34 0 0", we_cnt[0] - n, dout0, ferr[0], ovr[0]);
        end
    endtask

    task automatic test_line_quality;
        int n;
        n = we_cnt[0];
        din[0] = 1'b0;
        repeat (12) @(negedge clk);
        din[0] = 1'b1;
        repeat (100) @(negedge clk);
        tests++;
        if (we_cnt[0] - n !== 0) begin
            fails++;
            $display("FAIL glitch: we %0d want 0", we_cnt[0] - n);
        end
        send_frame(0, 9'h0C3, 8, 0, 1'b0, 1'b1, 1'b1, 1, 2);
        tests++;
        if (we_cnt[0] - n !== 1 || dout0 !== 8'hC3 || ferr[0] !== 1'b0) begin
            fails++;
            $display("FAIL spike: we %0d dout %h ferr %b want 1 c3 0", we_cnt[0] - n, dout0, ferr[0]);
        end
    endtask

    task automatic test_break;
        int n, b;
        n = we_cnt[0];
        b = brk_cnt[0];
`ifdef UART_RX_FRAME_BREAK_EN
        din[0] = 1'b0;
        repeat (640) @(negedge clk);
        din[0] = 1'b1;
        repeat (64) @(negedge clk);
        tests++;
        if (brk_cnt[0] - b !== 1 || we_cnt[0] - n !== 0 || ovr[0] !== 1'b0) begin
            fails++;
            $display("FAIL break: brk %0d we %0d ovr %b want 1 0 0", brk_cnt[0] - b, we_cnt[0] - n, ovr[0]);
        end
        send_frame(0, 9'h07E, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        tests++;
        if (we_cnt[0] - n !== 1 || dout0 !== 8'h7E || ferr[0] !== 1'b0) begin
            fails++;
            $display("FAIL post_break: we %0d dout %h ferr %b want 1 7e 0", we_cnt[0] - n, dout0, ferr[0]);
        end
`else
        send_frame(0, 9'h000, 8, 0, 1'b0, 1'b0, 1'b1, 1, -1);
        tests++;
        if (we_cnt[0] - n !== 1 || dout0 !== 8'h00 || ferr[0] !== 1'b1 || brk_cnt[0] - b !== 0) begin
            fails++;
            $display("FAIL zero_frame: we %0d dout %h ferr %b brk %0d want 1 00 1 0", we_cnt[0] - n, dout0, ferr[0], brk_cnt[0] - b);
        end
`endif
    endtask

    task automatic test_reset_midframe;
        int n;
        full = 1'b1;
        send_frame(0, 9'h099, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        full = 1'b0;
        tests++;
        if (ovr[0] !== 1'b1) begin
            fails++;
            $display("FAIL pre_abort_ovr: got %b want 1", ovr[0]);
        end
        n = we_cnt[0];
        send_bit(0, 1'b0, 1'b0);
        send_bit(0, 1'b1, 1'b0);
        send_bit(0, 1'b0, 1'b0);
        din[0] = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        tests++;
        if (we_cnt[0] - n !== 0 || ovr[0] !== 1'b0 || dout0 !== 8'h00) begin
            fails++;
            $display("FAIL abort: we %0d ovr %b dout %h want 0 0 00", we_cnt[0] - n, ovr[0], dout0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        din = 4'hF;
        full = 1'b0;
        ovr_clr = 1'b0;
        repeat (4) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        test_8n1();
        test_parity();
        test_framing();
        test_overrun();
        test_line_quality();
        test_break();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
